// File: rtl/divergence_controller_pkg.sv
// Shared types for the divergence controller: lane masks, addresses, register files,
// parked thread contexts, op encoding and FSM states.
package divergence_controller_pkg;

  localparam int NUM_LANES           = 8;
  localparam int ADDR_W              = 32;
  localparam int REGS_W              = 256;
  localparam int MAX_THREAD_CONTEXTS = 16;

  typedef logic [NUM_LANES-1:0] execution_mask_t;
  typedef logic [ADDR_W-1:0]    memory_address_t;
  typedef logic [REGS_W-1:0]    RegisterFile;
  typedef logic [$clog2(MAX_THREAD_CONTEXTS)-1:0] context_index_t;

  typedef struct packed {
    RegisterFile     regs;
    memory_address_t pc;
    execution_mask_t mask;
  } ThreadContext;

  typedef enum logic {
    OP_BRANCH = 1'b0,
    OP_EXIT   = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_COMMIT,
    S_POP,
    S_RESULT
  } state_e;

endpackage

// File: rtl/divergence_controller_if.sv
// Request, result and divergence-queue signals between execute, fetch and the queue.
// The controller uses the slave view; the surrounding pipeline uses the master view.
interface divergence_controller_if;
  import divergence_controller_pkg::*;

  logic            req_valid;
  logic            req_ready;
  op_e             req_op;
  execution_mask_t req_cond;
  execution_mask_t req_mask;
  memory_address_t req_target;
  memory_address_t req_fallthru;
  RegisterFile     req_regs;

  logic            res_valid;
  logic            res_ready;
  memory_address_t res_pc;
  execution_mask_t res_mask;
  RegisterFile     res_regs;
  logic            res_reload;
  logic            res_done;

  logic            q_push;
  RegisterFile     q_push_regs;
  memory_address_t q_push_pc;
  execution_mask_t q_push_mask;
  logic            q_adv_write;
  logic            q_adv_read;
  logic            q_full;
  logic            q_empty;
  RegisterFile     q_back_regs;
  memory_address_t q_back_pc;
  execution_mask_t q_back_mask;

  logic            err_overflow;

  modport slave (
    input  req_valid, req_op, req_cond, req_mask, req_target, req_fallthru, req_regs,
    output req_ready,
    input  res_ready,
    output res_valid, res_pc, res_mask, res_regs, res_reload, res_done,
    output q_push, q_push_regs, q_push_pc, q_push_mask, q_adv_write, q_adv_read,
    input  q_full, q_empty, q_back_regs, q_back_pc, q_back_mask,
    output err_overflow
  );

  modport master (
    output req_valid, req_op, req_cond, req_mask, req_target, req_fallthru, req_regs,
    input  req_ready,
    output res_ready,
    input  res_valid, res_pc, res_mask, res_regs, res_reload, res_done,
    input  q_push, q_push_regs, q_push_pc, q_push_mask, q_adv_write, q_adv_read,
    output q_full, q_empty, q_back_regs, q_back_pc, q_back_mask,
    input  err_overflow
  );

endinterface

// File: rtl/divergence_controller_mask_splitter.sv
// Splits the active execution mask by per-lane branch outcome and classifies the split.
module divergence_controller_mask_splitter
  import divergence_controller_pkg::*;
(
  input  execution_mask_t mask_i,
  input  execution_mask_t cond_i,
  output execution_mask_t taken_o,
  output execution_mask_t ntaken_o,
  output logic            is_divergent_o,
  output logic            is_empty_mask_o
);

  assign taken_o         = mask_i & cond_i;
  assign ntaken_o        = mask_i & ~cond_i;
  assign is_divergent_o  = (|taken_o) && (|ntaken_o);
  assign is_empty_mask_o = ~(|mask_i);

endmodule

// File: rtl/divergence_controller.sv
// Branch/exit sequencer: parks the not-taken half of a divergent warp in the divergence
// queue and restores the oldest parked context on warp exit.
module divergence_controller
  import divergence_controller_pkg::*;
(
  input logic                    clk,
  input logic                    reset_n,
  divergence_controller_if.slave bus
);

  state_e          state_q, state_d;
  ThreadContext    push_ctx_q, push_ctx_d;
  ThreadContext    res_ctx_q, res_ctx_d;
  logic            res_reload_q, res_reload_d;
  logic            res_done_q, res_done_d;
  logic            err_overflow_q, err_overflow_d;

  execution_mask_t taken, ntaken;
  logic            is_divergent, is_empty_mask;
  logic            is_exit;

  divergence_controller_mask_splitter u_mask_splitter (
    .mask_i          (bus.req_mask),
    .cond_i          (bus.req_cond),
    .taken_o         (taken),
    .ntaken_o        (ntaken),
    .is_divergent_o  (is_divergent),
    .is_empty_mask_o (is_empty_mask)
  );

  // A branch with no active lanes retires the warp just like an explicit exit.
  assign is_exit = (bus.req_op == OP_EXIT) || is_empty_mask;

  always_comb begin
    // NOTE: every value is defaulted to its held state first so no path infers a latch.
    state_d        = state_q;
    push_ctx_d     = push_ctx_q;
    res_ctx_d      = res_ctx_q;
    res_reload_d   = res_reload_q;
    res_done_d     = res_done_q;
    err_overflow_d = err_overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          res_reload_d = 1'b0;
          res_done_d   = 1'b0;
          if (is_exit) begin
            if (bus.q_empty) begin
              res_done_d = 1'b1;
              state_d    = S_RESULT;
            end else begin
              state_d = S_POP;
            end
          end else begin
            res_ctx_d.regs = bus.req_regs;
            if (|taken) begin
              res_ctx_d.pc   = bus.req_target;
              res_ctx_d.mask = taken;
            end else begin
              res_ctx_d.pc   = bus.req_fallthru;
              res_ctx_d.mask = ntaken;
            end
            if (is_divergent && bus.q_full) begin
              err_overflow_d = 1'b1;
              state_d        = S_RESULT;
            end else if (is_divergent) begin
              push_ctx_d = '{regs: bus.req_regs, pc: bus.req_fallthru, mask: ntaken};
              state_d    = S_PUSH;
            end else begin
              state_d = S_RESULT;
            end
          end
        end
      end
      // The queue writes the slot and moves its write pointer in separate cycles.
      S_PUSH:   state_d = S_COMMIT;
      S_COMMIT: state_d = S_RESULT;
      S_POP: begin
        res_ctx_d    = '{regs: bus.q_back_regs, pc: bus.q_back_pc, mask: bus.q_back_mask};
        res_reload_d = 1'b1;
        state_d      = S_RESULT;
      end
      S_RESULT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all registers sample together.
    if (!reset_n) begin
      state_q        <= S_IDLE;
      push_ctx_q     <= '0;
      res_ctx_q      <= '0;
      res_reload_q   <= 1'b0;
      res_done_q     <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      push_ctx_q     <= push_ctx_d;
      res_ctx_q      <= res_ctx_d;
      res_reload_q   <= res_reload_d;
      res_done_q     <= res_done_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.res_valid    = (state_q == S_RESULT);
  assign bus.res_pc       = res_ctx_q.pc;
  assign bus.res_mask     = res_ctx_q.mask;
  assign bus.res_regs     = res_ctx_q.regs;
  assign bus.res_reload   = res_reload_q;
  assign bus.res_done     = res_done_q;

  assign bus.q_push       = (state_q == S_PUSH);
  assign bus.q_push_regs  = push_ctx_q.regs;
  assign bus.q_push_pc    = push_ctx_q.pc;
  assign bus.q_push_mask  = push_ctx_q.mask;
  assign bus.q_adv_write  = (state_q == S_COMMIT);
  assign bus.q_adv_read   = (state_q == S_POP);

  assign bus.err_overflow = err_overflow_q;

endmodule
